memory1_stage: RTL and testbench
================================

MEMORY1_STAGE -- requirements
Module: memory1_stage

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-002 SHALL have ports: is_stall in 1, hold the pipeline register; is_flush in 1, kill the current instruction.
REQ-003 SHALL have ports: pass_in in execute_memory1_pass_t, the instruction from execute; excp_pass_in in excp_pass_t, its exception state.
REQ-004 SHALL have dcache request ports: dc_valid out 1; dc_ready in 1; dc_addr out 32; dc_wr out 1; dc_wstrb out 4; dc_wdata out 32.
REQ-005 SHALL have ports: mem1_req out forward_req_t, the forwarding source for execute; m1_stall out 1, to ctrl.
REQ-006 SHALL have ports: pass_out out memory1_memory2_pass_t; excp_pass_out out excp_pass_t.

Function
REQ-007 SHALL latch pass_in and excp_pass_in into the stage register on each clk when is_stall=0, and hold them when is_stall=1.
REQ-008 SHALL treat the instruction as killed when kill = is_flush | reg.is_flush | excp_pass_in_r.valid.
REQ-009 SHALL use ex_out of the registered instruction as the effective address.
REQ-010 SHALL raise ALE under these conditions:
- half access with addr[0]=1;
- word access with addr[1:0]!=0.
REQ-011 SHALL set the ALE result as follows:
- excp_pass_out.valid=1, ecode=ALE, badv=addr;
- no dcache request for that instruction.
REQ-012 SHALL drive store strobes as follows:
- byte: wstrb=1<<addr[1:0], wdata={4{rkd[7:0]}};
- half: wstrb=3<<addr[1:0], wdata={2{rkd[15:0]}};
- word: wstrb=4'hF, wdata=rkd.
REQ-013 SHALL set dc_addr={addr[31:2],2'b00} and dc_wr=is_store.
REQ-014 SHALL implement a request FSM with these states and transitions:
- IDLE -> REQ: on a new non-killed is_mem instruction without ALE.
- REQ -> SENT: on dc_valid&dc_ready.
- SENT -> IDLE: when the stage register advances (is_stall=0).
- REQ or SENT -> IDLE: when the register advances.
REQ-015 SHALL assert dc_valid only in REQ.
REQ-016 SHALL keep dc_valid and all request fields stable until accepted, unless kill is asserted before acceptance.
REQ-017 SHALL drop dc_valid in the same cycle a kill is asserted before acceptance, with the next state IDLE.
REQ-018 SHALL let an accepted request complete; a later kill only marks pass_out.is_flush.
REQ-019 SHALL issue exactly one dcache request per instruction, including across any number of is_stall cycles.
REQ-020 SHALL assert m1_stall while the state is REQ and dc_ready=0.
REQ-021 SHALL drive mem1_req as follows:
- valid = reg.is_wr_rd & ~kill & ~(is_mem&~is_store) & rd!=0;
- idx = rd;
- data = pc_plus4 if is_wr_rd_pc_plus4, else ex_out.
REQ-022 SHALL keep mem1_req.valid=0 for loads; the load-use stall upstream covers them.
REQ-023 SHALL set pass_out.is_flush = kill | m1_stall.
REQ-024 SHALL pass through pc, inst, rd, is_wr_rd, is_wr_rd_pc_plus4, is_wr_csr, csr_addr, is_mem, is_store, is_signed, byte_type, ex_out, is_cac, is_tlb, tlb_op and invtlb_asid.
REQ-025 SHALL add addr[1:0] to pass_out for load extraction in memory2.
REQ-026 SHALL forward excp_pass_in_r unchanged when no ALE is raised.
REQ-027 SHALL keep an earlier exception from excp_pass_in in priority over ALE.

Reset
REQ-028 SHALL, on rst, reset the following:
- FSM=IDLE;
- reg.is_flush=1;
- reg excp valid=0.
REQ-029 SHALL, in the first cycle after rst deasserts, hold outputs at:
- dc_valid=0, m1_stall=0;
- mem1_req.valid=0, pass_out.is_flush=1, excp_pass_out.valid=0.
REQ-030 SHALL, if rst is asserted mid-request, return to IDLE and deassert dc_valid in the next cycle.

Structure
REQ-031 SHALL define memory1_memory2_pass_t, the ALE ecode and the byte_type encodings in the shared cpu_defs package.
REQ-032 SHALL contain one combinational sub-module, StoreAlign, taking byte_type, addr[1:0] and rkd and producing wstrb and wdata.

Verification
REQ-033 SHALL cover a word store:
- stimulus: word store, addr=0x1004, rkd=0xDEADBEEF, dc_ready=1.
- required: one cycle with dc_valid, wstrb=F, wdata=0xDEADBEEF, dc_addr=0x1004.
REQ-034 SHALL cover a byte store:
- stimulus: byte store, addr=0x1003, rkd=0x12345678.
- required: wstrb=4'b1000, wdata=0x78787878.
REQ-035 SHALL cover a half-word load fault:
- stimulus: half load, addr=0x2001.
- required: dc_valid never asserted; excp_pass_out.valid=1, ecode=ALE, badv=0x2001.
REQ-036 SHALL cover backpressure:
- stimulus: load with dc_ready=0 for 3 cycles, then 1.
- required: m1_stall=1 for 3 cycles; fields stable; exactly one handshake.
REQ-037 SHALL cover acceptance under stall:
- stimulus: request accepted, then is_stall=1 for 4 cycles.
- required: FSM in SENT; no second dc_valid.
REQ-038 SHALL cover forwarding and flush:
- stimulus 1: add with rd=5, ex_out=0x7.
- required 1: mem1_req={1,5,0x7}.
- stimulus 2: is_flush in a REQ cycle before acceptance.
- required 2: dc_valid drops the same cycle; pass_out.is_flush=1.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared pipeline types for the memory1 stage: pass structs between stages,
// exception record, forwarding request, access-size encoding and ALE code.
package cpu_defs;

  typedef enum logic [1:0] {
    BT_BYTE = 2'd0,
    BT_HALF = 2'd1,
    BT_WORD = 2'd2
  } byte_type_t;

  // Address-alignment exception code
  localparam logic [5:0] ECODE_ALE = 6'h09;

  typedef struct packed {
    logic        valid;
    logic [5:0]  ecode;
    logic [31:0] badv;
  } excp_pass_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  idx;
    logic [31:0] data;
  } forward_req_t;

  typedef struct packed {
    logic        is_flush;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        is_wr_rd;
    logic        is_wr_rd_pc_plus4;
    logic        is_wr_csr;
    logic [13:0] csr_addr;
    logic        is_mem;
    logic        is_store;
    logic        is_signed;
    byte_type_t  byte_type;
    logic [31:0] ex_out;
    logic [31:0] rkd;
    logic        is_cac;
    logic        is_tlb;
    logic [4:0]  tlb_op;
    logic [9:0]  invtlb_asid;
  } execute_memory1_pass_t;

  typedef struct packed {
    logic        is_flush;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        is_wr_rd;
    logic        is_wr_rd_pc_plus4;
    logic        is_wr_csr;
    logic [13:0] csr_addr;
    logic        is_mem;
    logic        is_store;
    logic        is_signed;
    byte_type_t  byte_type;
    logic [31:0] ex_out;
    logic        is_cac;
    logic        is_tlb;
    logic [4:0]  tlb_op;
    logic [9:0]  invtlb_asid;
    logic [1:0]  addr_lo;   // byte offset used by memory2 for load extraction
  } memory1_memory2_pass_t;

  // True when the access is not naturally aligned for its size
  function automatic logic is_misaligned(input byte_type_t bt, input logic [1:0] lo);
    case (bt)
      BT_BYTE: return 1'b0;
      BT_HALF: return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/StoreAlign.sv
// Store lane steering: builds byte strobes and replicated write data
// from the access size and the low address bits.
module StoreAlign
  import cpu_defs::*;
(
  input  byte_type_t  byte_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rkd,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata
);

  // Replicate the store operand across all lanes and enable only the addressed ones
  always_comb begin
    wstrb = 4'hF;
    wdata = rkd;
    case (byte_type)
      BT_BYTE: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{rkd[7:0]}};
      end
      BT_HALF: begin
        wstrb = 4'b0011 << addr_lo;
        wdata = {2{rkd[15:0]}};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/memory1_stage.sv
// Memory1 pipeline stage: holds the instruction from execute, checks
// alignment, issues exactly one dcache request per memory instruction and
// provides the forwarding source for non-load results.
module memory1_stage
  import cpu_defs::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  is_stall,
  input  logic                  is_flush,
  input  execute_memory1_pass_t pass_in,
  input  excp_pass_t            excp_pass_in,
  output logic                  dc_valid,
  input  logic                  dc_ready,
  output logic [31:0]           dc_addr,
  output logic                  dc_wr,
  output logic [3:0]            dc_wstrb,
  output logic [31:0]           dc_wdata,
  output forward_req_t          mem1_req,
  output logic                  m1_stall,
  output memory1_memory2_pass_t pass_out,
  output excp_pass_t            excp_pass_out
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SENT} req_state_t;

  req_state_t            state_q, state_d;
  execute_memory1_pass_t pass_q;
  excp_pass_t            excp_q;
  logic                  kill;
  logic                  ale;
  logic                  new_req;
  logic [31:0]           addr;
  logic [3:0]            strb_raw;

  assign addr = pass_q.ex_out;
  assign kill = is_flush | pass_q.is_flush | excp_q.valid;
  // An older exception already owns the instruction, so ALE only fires on clean ones
  assign ale  = pass_q.is_mem & ~pass_q.is_flush & ~excp_q.valid
              & is_misaligned(pass_q.byte_type, addr[1:0]);
  // Decide at latch time whether the incoming instruction needs the dcache
  assign new_req = pass_in.is_mem & ~pass_in.is_flush & ~excp_pass_in.valid
                 & ~is_misaligned(pass_in.byte_type, pass_in.ex_out[1:0]);

  // Stage register: capture from execute unless stalled; reset leaves a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q          <= '0;
      pass_q.is_flush <= 1'b1;
      excp_q          <= '0;
    end else if (!is_stall) begin
      pass_q <= pass_in;
      excp_q <= excp_pass_in;
    end
  end

  // Request FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Request FSM next state and handshake outputs
  always_comb begin
    state_d  = state_q;
    dc_valid = 1'b0;
    m1_stall = 1'b0;
    if (!is_stall) begin
      state_d = new_req ? S_REQ : S_IDLE;
    end else if (state_q == S_REQ) begin
      if (kill)          state_d = S_IDLE;
      else if (dc_ready) state_d = S_SENT;
    end
    if (state_q == S_REQ) begin
      dc_valid = ~kill;
      m1_stall = ~dc_ready;
    end
  end

  StoreAlign u_store_align (
    .byte_type (pass_q.byte_type),
    .addr_lo   (addr[1:0]),
    .rkd       (pass_q.rkd),
    .wstrb     (strb_raw),
    .wdata     (dc_wdata)
  );

  assign dc_addr  = {addr[31:2], 2'b00};
  assign dc_wr    = pass_q.is_store;
  assign dc_wstrb = pass_q.is_store ? strb_raw : 4'h0;

  // Forwarding source; loads are excluded because their data is not ready yet
  always_comb begin
    mem1_req.valid = pass_q.is_wr_rd & ~kill & ~(pass_q.is_mem & ~pass_q.is_store)
                   & (pass_q.rd != 5'd0);
    mem1_req.idx   = pass_q.rd;
    mem1_req.data  = pass_q.is_wr_rd_pc_plus4 ? pass_q.pc_plus4 : pass_q.ex_out;
  end

  // Exception merge: older exception wins, otherwise report ALE with the bad address
  always_comb begin
    excp_pass_out = excp_q;
    if (!excp_q.valid && ale) begin
      excp_pass_out.valid = 1'b1;
      excp_pass_out.ecode = ECODE_ALE;
      excp_pass_out.badv  = addr;
    end
  end

  // Pass-through to memory2
  always_comb begin
    pass_out.is_flush          = kill | m1_stall;
    pass_out.pc                = pass_q.pc;
    pass_out.inst              = pass_q.inst;
    pass_out.rd                = pass_q.rd;
    pass_out.is_wr_rd          = pass_q.is_wr_rd;
    pass_out.is_wr_rd_pc_plus4 = pass_q.is_wr_rd_pc_plus4;
    pass_out.is_wr_csr         = pass_q.is_wr_csr;
    pass_out.csr_addr          = pass_q.csr_addr;
    pass_out.is_mem            = pass_q.is_mem;
    pass_out.is_store          = pass_q.is_store;
    pass_out.is_signed         = pass_q.is_signed;
    pass_out.byte_type         = pass_q.byte_type;
    pass_out.ex_out            = pass_q.ex_out;
    pass_out.is_cac            = pass_q.is_cac;
    pass_out.is_tlb            = pass_q.is_tlb;
    pass_out.tlb_op            = pass_q.tlb_op;
    pass_out.invtlb_asid       = pass_q.invtlb_asid;
    pass_out.addr_lo           = addr[1:0];
  end

endmodule

// File: tb/tb_memory1_stage.sv
// Self-checking bench for memory1_stage: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_memory1_stage;
  import cpu_defs::*;

  logic                  clk = 1'b0;
  logic                  rst, is_stall, is_flush, dc_ready;
  execute_memory1_pass_t pass_in;
  excp_pass_t            excp_pass_in;
  logic                  dc_valid, dc_wr, m1_stall;
  logic [31:0]           dc_addr, dc_wdata;
  logic [3:0]            dc_wstrb;
  forward_req_t          mem1_req;
  memory1_memory2_pass_t pass_out;
  excp_pass_t            excp_pass_out;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;

  always #5 clk = ~clk;

  memory1_stage dut (
    .clk(clk), .rst(rst), .is_stall(is_stall), .is_flush(is_flush),
    .pass_in(pass_in), .excp_pass_in(excp_pass_in),
    .dc_valid(dc_valid), .dc_ready(dc_ready), .dc_addr(dc_addr), .dc_wr(dc_wr),
    .dc_wstrb(dc_wstrb), .dc_wdata(dc_wdata),
    .mem1_req(mem1_req), .m1_stall(m1_stall),
    .pass_out(pass_out), .excp_pass_out(excp_pass_out)
  );

  // ---------------- behavioural model ----------------
  execute_memory1_pass_t m_reg;
  excp_pass_t            m_exc;
  bit                    m_pending;   // instruction still owes its one dcache request
  bit                    e_kill, e_ale, e_dc_valid, e_m1_stall;
  forward_req_t          e_fwd;
  excp_pass_t            e_exc;
  logic [3:0]            e_wstrb;
  logic [31:0]           e_wdata;

  function automatic int acc_size(input byte_type_t bt);
    return (bt == BT_BYTE) ? 1 : (bt == BT_HALF) ? 2 : 4;
  endfunction

  function automatic bit bad_align(input byte_type_t bt, input logic [31:0] a);
    return (int'(a[1:0]) % acc_size(bt)) != 0;
  endfunction

  task automatic model_eval();
    int sz;
    int off;
    e_kill     = is_flush | m_reg.is_flush | m_exc.valid;
    e_ale      = m_reg.is_mem && !m_reg.is_flush && !m_exc.valid && bad_align(m_reg.byte_type, m_reg.ex_out);
    e_dc_valid = m_pending && !e_kill;
    e_m1_stall = m_pending && !dc_ready;
    e_fwd.valid = m_reg.is_wr_rd && !e_kill && !(m_reg.is_mem && !m_reg.is_store) && (m_reg.rd != 5'd0);
    e_fwd.idx   = m_reg.rd;
    e_fwd.data  = m_reg.is_wr_rd_pc_plus4 ? m_reg.pc_plus4 : m_reg.ex_out;
    e_exc = m_exc;
    if (!m_exc.valid && e_ale) begin
      e_exc.valid = 1'b1;
      e_exc.ecode = ECODE_ALE;
      e_exc.badv  = m_reg.ex_out;
    end
    sz  = acc_size(m_reg.byte_type);
    off = int'(m_reg.ex_out[1:0]);
    if (sz == 1) begin
      e_wstrb = 4'(1 << off);
      e_wdata = {24'h0, m_reg.rkd[7:0]} * 32'h0101_0101;
    end else if (sz == 2) begin
      e_wstrb = 4'(3 << off);
      e_wdata = {16'h0, m_reg.rkd[15:0]} * 32'h0001_0001;
    end else begin
      e_wstrb = 4'hF;
      e_wdata = m_reg.rkd;
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_reg = '0;
      m_reg.is_flush = 1'b1;
      m_exc = '0;
      m_pending = 1'b0;
    end else if (!is_stall) begin
      m_reg = pass_in;
      m_exc = excp_pass_in;
      m_pending = pass_in.is_mem && !pass_in.is_flush && !excp_pass_in.valid
                  && !bad_align(pass_in.byte_type, pass_in.ex_out);
    end else if (e_dc_valid && dc_ready) begin
      m_pending = 1'b0;
    end else if (e_kill) begin
      m_pending = 1'b0;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare every output against the model, then advance one clock
  task automatic cyc();
    #1;
    model_eval();
    chk("dc_valid", 64'(dc_valid), 64'(e_dc_valid));
    chk("m1_stall", 64'(m1_stall), 64'(e_m1_stall));
    chk("flush_out", 64'(pass_out.is_flush), 64'(e_kill | e_m1_stall));
    chk("mem1_req", 64'(mem1_req), 64'(e_fwd));
    chk("excp_out", 64'(excp_pass_out), 64'(e_exc));
    chk("pass_pc_ex", {pass_out.pc, pass_out.ex_out}, {m_reg.pc, m_reg.ex_out});
    chk("pass_rd_lo", 64'({pass_out.rd, pass_out.addr_lo, pass_out.inst}),
        64'({m_reg.rd, m_reg.ex_out[1:0], m_reg.inst}));
    if (e_dc_valid) begin
      chk("dc_addr", 64'(dc_addr), 64'({m_reg.ex_out[31:2], 2'b00}));
      chk("dc_wr", 64'(dc_wr), 64'(m_reg.is_store));
      if (m_reg.is_store) begin
        chk("dc_wstrb", 64'(dc_wstrb), 64'(e_wstrb));
        chk("dc_wdata", 64'(dc_wdata), 64'(e_wdata));
      end
    end
    if (dc_valid && dc_ready) hs_count++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic execute_memory1_pass_t mk(input bit mem, input bit st, input byte_type_t bt,
                                               input logic [31:0] addr, input logic [31:0] rkd);
    execute_memory1_pass_t p;
    p = '0;
    p.pc        = 32'h1c00_0000 + addr;
    p.pc_plus4  = p.pc + 32'd4;
    p.inst      = 32'h2880_0000 ^ addr;
    p.is_mem    = mem;
    p.is_store  = st;
    p.byte_type = bt;
    p.ex_out    = addr;
    p.rkd       = rkd;
    p.rd        = st ? 5'd0 : 5'd4;
    p.is_wr_rd  = !st;
    return p;
  endfunction

  task automatic set_in(input execute_memory1_pass_t p, input bit stall, input bit flush, input bit ready);
    pass_in      = p;
    excp_pass_in = '0;
    is_stall     = stall;
    is_flush     = flush;
    dc_ready     = ready;
  endtask

  typedef struct {
    byte_type_t  bt;
    bit          st;
    logic [31:0] addr;
    logic [31:0] rkd;
    bit          exp_req;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    bit          exp_ale;
  } vec_t;

  vec_t vecs[8];
  execute_memory1_pass_t bubble;
  execute_memory1_pass_t p;
  int hs0;

  initial begin
    vecs[0] = '{BT_WORD, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{BT_BYTE, 1'b1, 32'h0000_1003, 32'h1234_5678, 1'b1, 4'h8, 32'h7878_7878, 1'b0};
    vecs[2] = '{BT_HALF, 1'b0, 32'h0000_2001, 32'h0000_0000, 1'b0, 4'h0, 32'h0000_0000, 1'b1};
    vecs[3] = '{BT_HALF, 1'b1, 32'h0000_2002, 32'hAABB_CCDD, 1'b1, 4'hC, 32'hCCDD_CCDD, 1'b0};
    vecs[4] = '{BT_BYTE, 1'b1, 32'h0000_1000, 32'h0000_0011, 1'b1, 4'h1, 32'h1111_1111, 1'b0};
    vecs[5] = '{BT_WORD, 1'b0, 32'h0000_3002, 32'h0000_0000, 1'b0, 4'h0, 32'h0000_0000, 1'b1};
    vecs[6] = '{BT_WORD, 1'b0, 32'h0000_3008, 32'h0000_0000, 1'b1, 4'h0, 32'h0000_0000, 1'b0};
    vecs[7] = '{BT_BYTE, 1'b0, 32'h0000_3001, 32'h0000_0000, 1'b1, 4'h0, 32'h0000_0000, 1'b0};

    bubble = '0;
    bubble.is_flush = 1'b1;

    // Reset
    set_in(bubble, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_update();
    #1;
    rst = 1'b0;
    #1;
    chk("rst_dc_valid", 64'(dc_valid), 64'(0));
    chk("rst_m1_stall", 64'(m1_stall), 64'(0));
    chk("rst_fwd_valid", 64'(mem1_req.valid), 64'(0));
    chk("rst_flush_out", 64'(pass_out.is_flush), 64'(1));
    chk("rst_excp_valid", 64'(excp_pass_out.valid), 64'(0));
    cyc();

    // Directed vector table: one instruction each, held two cycles after latching
    for (int i = 0; i < 8; i++) begin
      hs0 = hs_count;
      set_in(mk(1'b1, vecs[i].st, vecs[i].bt, vecs[i].addr, vecs[i].rkd), 1'b0, 1'b0, 1'b1);
      cyc();
      set_in(bubble, 1'b1, 1'b0, 1'b1);
      #1;
      chk("vec_dc_valid", 64'(dc_valid), 64'(vecs[i].exp_req));
      if (vecs[i].exp_req) chk("vec_dc_addr", 64'(dc_addr), 64'(vecs[i].addr & 32'hFFFF_FFFC));
      if (vecs[i].exp_req && vecs[i].st) begin
        chk("vec_wstrb", 64'(dc_wstrb), 64'(vecs[i].exp_strb));
        chk("vec_wdata", 64'(dc_wdata), 64'(vecs[i].exp_wdata));
      end
      chk("vec_ale", 64'(excp_pass_out.valid), 64'(vecs[i].exp_ale));
      if (vecs[i].exp_ale)
        chk("vec_ale_info", 64'({excp_pass_out.ecode, excp_pass_out.badv}), 64'({ECODE_ALE, vecs[i].addr}));
      cyc();
      chk("vec_no_second", 64'(dc_valid), 64'(0));
      cyc();
      chk("vec_handshakes", 64'(hs_count - hs0), 64'(vecs[i].exp_req));
      set_in(bubble, 1'b0, 1'b0, 1'b1);
      cyc();
      $display("vec %0d bt=%0d st=%0d addr=%h done", i, vecs[i].bt, vecs[i].st, vecs[i].addr);
    end

    // Backpressure, then acceptance followed by a long stall
    hs0 = hs_count;
    set_in(mk(1'b1, 1'b0, BT_WORD, 32'h0000_4000, 32'h0), 1'b0, 1'b0, 1'b0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      set_in(bubble, 1'b1, 1'b0, 1'b0);
      #1;
      chk("bp_m1_stall", 64'(m1_stall), 64'(1));
      chk("bp_dc_valid", 64'(dc_valid), 64'(1));
      chk("bp_dc_addr", 64'(dc_addr), 64'(32'h0000_4000));
      cyc();
    end
    set_in(bubble, 1'b1, 1'b0, 1'b1);
    #1;
    chk("bp_accept_valid", 64'(dc_valid), 64'(1));
    chk("bp_accept_stall", 64'(m1_stall), 64'(0));
    cyc();
    for (int k = 0; k < 4; k++) begin
      set_in(bubble, 1'b1, 1'b0, 1'b1);
      #1;
      chk("sent_no_valid", 64'(dc_valid), 64'(0));
      cyc();
    end
    chk("bp_handshakes", 64'(hs_count - hs0), 64'(1));
    set_in(bubble, 1'b0, 1'b0, 1'b1);
    cyc();
    $display("seq backpressure done");

    // Flush before acceptance
    hs0 = hs_count;
    set_in(mk(1'b1, 1'b1, BT_WORD, 32'h0000_5000, 32'hCAFE_0000), 1'b0, 1'b0, 1'b0);
    cyc();
    set_in(bubble, 1'b1, 1'b1, 1'b0);
    #1;
    chk("flush_dc_valid", 64'(dc_valid), 64'(0));
    chk("flush_pass_out", 64'(pass_out.is_flush), 64'(1));
    cyc();
    set_in(bubble, 1'b1, 1'b0, 1'b1);
    #1;
    chk("flush_idle", 64'(dc_valid), 64'(0));
    cyc();
    chk("flush_handshakes", 64'(hs_count - hs0), 64'(0));
    set_in(bubble, 1'b0, 1'b0, 1'b1);
    cyc();
    $display("seq flush done");

    // Forwarding
    p = '0; p.rd = 5'd5; p.is_wr_rd = 1'b1; p.ex_out = 32'h7;
    set_in(p, 1'b0, 1'b0, 1'b1);
    cyc();
    chk("fwd_add", 64'(mem1_req), 64'({1'b1, 5'd5, 32'h7}));
    p = '0; p.rd = 5'd1; p.is_wr_rd = 1'b1; p.is_wr_rd_pc_plus4 = 1'b1; p.pc_plus4 = 32'h1c00_0008; p.ex_out = 32'h99;
    set_in(p, 1'b0, 1'b0, 1'b1);
    cyc();
    chk("fwd_pc4", 64'(mem1_req), 64'({1'b1, 5'd1, 32'h1c00_0008}));
    p.rd = 5'd0;
    set_in(p, 1'b0, 1'b0, 1'b1);
    cyc();
    chk("fwd_r0", 64'(mem1_req.valid), 64'(0));
    set_in(mk(1'b1, 1'b0, BT_WORD, 32'h0000_0040, 32'h0), 1'b0, 1'b0, 1'b1);
    cyc();
    chk("fwd_load", 64'(mem1_req.valid), 64'(0));
    $display("seq forwarding done");

    // Earlier exception wins over ALE
    set_in(mk(1'b1, 1'b0, BT_HALF, 32'h0000_2001, 32'h0), 1'b0, 1'b0, 1'b1);
    excp_pass_in = '{valid: 1'b1, ecode: 6'h03, badv: 32'h55};
    cyc();
    set_in(bubble, 1'b1, 1'b0, 1'b1);
    #1;
    chk("excp_priority", 64'(excp_pass_out), 64'({1'b1, 6'h03, 32'h55}));
    chk("excp_no_req", 64'(dc_valid), 64'(0));
    cyc();
    set_in(bubble, 1'b0, 1'b0, 1'b1);
    cyc();
    $display("seq exception priority done");

    // Reset while a request is pending
    set_in(mk(1'b1, 1'b0, BT_WORD, 32'h0000_6000, 32'h0), 1'b0, 1'b0, 1'b0);
    cyc();
    set_in(bubble, 1'b1, 1'b0, 1'b0);
    #1;
    chk("mid_rst_before", 64'(dc_valid), 64'(1));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("mid_rst_dc_valid", 64'(dc_valid), 64'(0));
    chk("mid_rst_flush", 64'(pass_out.is_flush), 64'(1));
    cyc();
    set_in(bubble, 1'b0, 1'b0, 1'b1);
    cyc();
    $display("seq reset mid-request done");

    // Randomized traffic; ctrl stalls the pipe whenever memory1 asks for it
    for (int i = 0; i < 600; i++) begin
      p = '0;
      p.pc                = $urandom;
      p.pc_plus4          = p.pc + 32'd4;
      p.inst              = $urandom;
      p.rd                = 5'($urandom_range(0, 31));
      p.is_wr_rd          = 1'($urandom_range(0, 1));
      p.is_wr_rd_pc_plus4 = ($urandom_range(0, 3) == 0);
      p.is_mem            = 1'($urandom_range(0, 1));
      p.is_store          = 1'($urandom_range(0, 1));
      p.byte_type         = byte_type_t'(2'($urandom_range(0, 2)));
      p.ex_out            = $urandom;
      p.rkd               = $urandom;
      p.is_flush          = ($urandom_range(0, 7) == 0);
      p.csr_addr          = 14'($urandom);
      p.tlb_op            = 5'($urandom);
      p.invtlb_asid       = 10'($urandom);
      pass_in = p;
      excp_pass_in = '0;
      if ($urandom_range(0, 9) == 0) begin
        excp_pass_in.valid = 1'b1;
        excp_pass_in.ecode = 6'($urandom_range(1, 20));
        excp_pass_in.badv  = $urandom;
      end
      is_flush = ($urandom_range(0, 9) == 0);
      dc_ready = 1'($urandom_range(0, 1));
      model_eval();
      is_stall = e_m1_stall | ($urandom_range(0, 3) == 0);
      cyc();
    end
    $display("random traffic done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
